// File: rtl/laser_peak_detect_if.sv
// Pixel-stream input and per-line peak result bundle for laser_peak_detect.
// peak_col widens to 11 bits when LASER_PEAK_HALF_PX_EN is defined.
interface laser_peak_detect_if;
`ifdef LASER_PEAK_HALF_PX_EN
  localparam int COL_OUT_W = 11;
`else
  localparam int COL_OUT_W = 10;
`endif

  logic [7:0]           px_in;
  logic [2:0]           fvh_in;
  logic                 dv_in;
  logic [COL_OUT_W-1:0] peak_col;
  logic [9:0]           peak_row;
  logic [7:0]           peak_val;
  logic                 peak_found;
  logic                 peak_valid;
  logic                 frame_done;

  modport master (
    output px_in, fvh_in, dv_in,
    input  peak_col, peak_row, peak_val, peak_found, peak_valid, frame_done
  );

  modport slave (
    input  px_in, fvh_in, dv_in,
    output peak_col, peak_row, peak_val, peak_found, peak_valid, frame_done
  );
endinterface

// File: rtl/laser_peak_detect.sv
// Per-line laser peak finder: tracks the row maximum, emits it on hblank rise.
// Optional macro LASER_PEAK_HALF_PX_EN adds half-pixel column refinement.
module laser_peak_detect #(
  parameter int         IMG_WIDTH = 720,
  parameter logic [7:0] THRESHOLD = 8'd40
) (
  input logic                clk,
  input logic                reset,
  laser_peak_detect_if.slave bus
);
`ifdef LASER_PEAK_HALF_PX_EN
  localparam int COL_OUT_W = 11;
`else
  localparam int COL_OUT_W = 10;
`endif
  localparam logic [9:0] COL_MAX = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] ROW_MAX = 10'd1023;

  typedef enum logic [1:0] {SYNC, BLANK, LINE, EMIT} state_t;
  state_t state_q, state_d;

  logic                 hb_q, vb_q;
  logic [9:0]           col_q, col_d, max_col_q, max_col_d, row_q, row_d;
  logic [7:0]           max_q, max_d;
  logic [COL_OUT_W-1:0] peak_col_q, peak_col_d;
  logic [9:0]           peak_row_q, peak_row_d;
  logic [7:0]           peak_val_q, peak_val_d;
  logic                 peak_found_q, peak_found_d;
  logic                 peak_valid_q, frame_done_q, frame_done_d;

  logic accept, hb_rise, vb_rise;
  logic first_px, next_px, emit;
  logic unused_field;

  assign unused_field = bus.fvh_in[2];
  assign accept  = bus.dv_in && (bus.fvh_in[1:0] == 2'b00);
  assign hb_rise = !hb_q && bus.fvh_in[0];
  assign vb_rise = !vb_q && bus.fvh_in[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (bus.fvh_in[0]) state_d = BLANK;
      BLANK:   if (accept)        state_d = LINE;
      LINE:    if (hb_rise)       state_d = EMIT;
      EMIT:                       state_d = BLANK;
      default:                    state_d = SYNC;
    endcase
  end

  // A line opens on its first accepted pixel; later pixels past the last column are dropped.
  always_comb begin
    first_px = (state_q == BLANK) && accept;
    next_px  = (state_q == LINE) && accept && (col_q < COL_MAX);
    emit     = (state_q == LINE) && hb_rise;
  end

  always_comb begin
    col_d     = col_q;
    max_d     = max_q;
    max_col_d = max_col_q;
    if (first_px) begin
      col_d     = '0;
      max_d     = bus.px_in;
      max_col_d = '0;
    end else if (next_px) begin
      col_d = col_q + 10'd1;
      if (bus.px_in > max_q) begin
        max_d     = bus.px_in;
        max_col_d = col_q + 10'd1;
      end
    end
  end

`ifdef LASER_PEAK_HALF_PX_EN
  logic [7:0] prev_q, prev_d, left_q, left_d, right_q, right_d;
  logic       need_right_q, need_right_d;

  function automatic logic [10:0] half_px_col(input logic [9:0] col,
                                              input logic [7:0] l,
                                              input logic [7:0] r);
    logic [10:0] base;
    base = {col, 1'b0};
    if (l > r)      return base - 11'd1;
    else if (r > l) return base + 11'd1;
    else            return base;
  endfunction

  // Left neighbour latches on each new maximum; right waits for the next accepted pixel.
  always_comb begin
    prev_d       = prev_q;
    left_d       = left_q;
    right_d      = right_q;
    need_right_d = need_right_q;
    if (first_px) begin
      prev_d       = bus.px_in;
      left_d       = '0;
      right_d      = '0;
      need_right_d = 1'b1;
    end else if (next_px) begin
      prev_d = bus.px_in;
      if (bus.px_in > max_q) begin
        left_d       = prev_q;
        right_d      = '0;
        need_right_d = 1'b1;
      end else if (need_right_q) begin
        right_d      = bus.px_in;
        need_right_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q       <= '0;
      left_q       <= '0;
      right_q      <= '0;
      need_right_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      left_q       <= left_d;
      right_q      <= right_d;
      need_right_q <= need_right_d;
    end
  end

  assign peak_col_d = emit ? half_px_col(max_col_q, left_q, right_q) : peak_col_q;
`else
  assign peak_col_d = emit ? max_col_q : peak_col_q;
`endif

  // Row index is captured pre-clear, so a coincident vblank still reports the last row.
  always_comb begin
    row_d        = row_q;
    frame_done_d = 1'b0;
    peak_row_d   = emit ? row_q : peak_row_q;
    peak_val_d   = emit ? max_q : peak_val_q;
    peak_found_d = emit ? (max_q >= THRESHOLD) : peak_found_q;
    if (emit && (row_q != ROW_MAX)) row_d = row_q + 10'd1;
    if (vb_rise) begin
      row_d        = '0;
      frame_done_d = (state_q != SYNC) && (row_q != 10'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hb_q         <= 1'b0;
      vb_q         <= 1'b0;
      col_q        <= '0;
      max_q        <= '0;
      max_col_q    <= '0;
      row_q        <= '0;
      peak_col_q   <= '0;
      peak_row_q   <= '0;
      peak_val_q   <= '0;
      peak_found_q <= 1'b0;
      peak_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      hb_q         <= bus.fvh_in[0];
      vb_q         <= bus.fvh_in[1];
      col_q        <= col_d;
      max_q        <= max_d;
      max_col_q    <= max_col_d;
      row_q        <= row_d;
      peak_col_q   <= peak_col_d;
      peak_row_q   <= peak_row_d;
      peak_val_q   <= peak_val_d;
      peak_found_q <= peak_found_d;
      peak_valid_q <= emit;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.peak_col   = peak_col_q;
  assign bus.peak_row   = peak_row_q;
  assign bus.peak_val   = peak_val_q;
  assign bus.peak_found = peak_found_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_laser_peak_detect.sv
// Bench for laser_peak_detect: table of line patterns, hand-written frame/reset
// sequences and randomized lines against a line-level reference model.
`timescale 1ns/1ps
module tb_laser_peak_detect;
`ifdef LASER_PEAK_HALF_PX_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif
  localparam int W   = 720;
  localparam int THR = 40;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  laser_peak_detect_if bus();

  laser_peak_detect #(.IMG_WIDTH(W), .THRESHOLD(8'd40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string name;
    int bg;
    int c1, v1, c2, v2, c3, v3;
    int exp_col, exp_hcol, exp_val, exp_found;
  } vec_t;

  vec_t tab[12];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] line_px[0:799];
  int line_len;
  int m_row;
  bit m_armed;
  int last_val, last_col, last_row, last_found;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [7:0] px, input logic [2:0] fvh, input logic dv);
    bus.px_in  = px;
    bus.fvh_in = fvh;
    bus.dv_in  = dv;
    @(posedge clk);
    #1;
  endtask

  // Reference: argmax (first wins) over the first W accepted pixels, with neighbours.
  function automatic void model(output int col, output int hcol, output int val);
    int n = (line_len > W) ? W : line_len;
    int idx = 0;
    int l, r;
    for (int i = 1; i < n; i++)
      if (line_px[i] > line_px[idx]) idx = i;
    l = (idx > 0) ? int'(line_px[idx-1]) : 0;
    r = (idx < n - 1) ? int'(line_px[idx+1]) : 0;
    col  = idx;
    val  = line_px[idx];
    hcol = 2 * idx + ((l > r) ? -1 : ((r > l) ? 1 : 0));
  endfunction

  task automatic px_line(input bit gaps);
    bit spur = 1'b0;
    repeat (2) begin
      cyc(8'd0, 3'b000, 1'b0);
      spur |= bus.peak_valid | bus.frame_done;
    end
    for (int i = 0; i < line_len; i++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) begin
        cyc(8'($urandom), 3'b000, 1'b0);
        spur |= bus.peak_valid | bus.frame_done;
      end
      cyc(line_px[i], 3'b000, 1'b1);
      spur |= bus.peak_valid | bus.frame_done;
    end
    check("no_strobe_during_line", int'(spur), 0);
  endtask

  task automatic end_line(input bit vb, input int e_col, input int e_val, input int e_found);
    bit ev  = m_armed && (line_len > 0);
    bit efd = vb && m_armed && (m_row != 0);
    logic [2:0] f = vb ? 3'b011 : 3'b001;
    cyc(8'hFF, f, 1'b1);
    check("peak_valid", int'(bus.peak_valid), int'(ev));
    check("frame_done", int'(bus.frame_done), int'(efd));
    if (ev) begin
      check("peak_col",   int'(bus.peak_col),   e_col);
      check("peak_val",   int'(bus.peak_val),   e_val);
      check("peak_found", int'(bus.peak_found), e_found);
      check("peak_row",   int'(bus.peak_row),   m_row);
      last_col = e_col; last_val = e_val; last_found = e_found; last_row = m_row;
      if (m_row < 1023) m_row++;
    end
    if (vb) m_row = 0;
    m_armed = 1'b1;
    cyc(8'hFF, f, 1'b1);
    check("valid_one_cycle", int'(bus.peak_valid), 0);
    check("frame_done_one_cycle", int'(bus.frame_done), 0);
    check("hold_val", int'(bus.peak_val), last_val);
    check("hold_col", int'(bus.peak_col), last_col);
    check("hold_row", int'(bus.peak_row), last_row);
    repeat (2) cyc(8'($urandom), f, 1'b1);
    if (vb) repeat (2) cyc(8'd0, 3'b001, 1'b0);
  endtask

  task automatic model_line(input bit vb, input bit gaps);
    int c, h, v;
    model(c, h, v);
    px_line(gaps);
    end_line(vb, HALF ? h : c, v, int'(v >= THR));
  endtask

  task automatic vblank_only();
    bit efd = m_armed && (m_row != 0);
    cyc(8'd0, 3'b011, 1'b0);
    check("vblank_frame_done", int'(bus.frame_done), int'(efd));
    check("vblank_no_valid", int'(bus.peak_valid), 0);
    m_row = 0;
    m_armed = 1'b1;
    cyc(8'd0, 3'b011, 1'b1);
    check("vblank_done_one_cycle", int'(bus.frame_done), 0);
    repeat (3) cyc(8'($urandom), 3'b011, 1'b1);
    repeat (2) cyc(8'd0, 3'b001, 1'b0);
  endtask

  task automatic rand_line(input int len, input int maxv);
    line_len = len;
    for (int i = 0; i < len; i++) line_px[i] = 8'($urandom_range(0, maxv));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = '{"single_peak", 10, 300, 200, -1,   0, -1,   0, 300,  600, 200, 1};
    tab[1]  = '{"tie_first",    5, 100,  90, 500, 90, -1,   0, 100,  200,  90, 1};
    tab[2]  = '{"flat_30",     30,  -1,   0, -1,   0, -1,   0,   0,    1,  30, 0};
    tab[3]  = '{"flat_40",     40,  -1,   0, -1,   0, -1,   0,   0,    1,  40, 1};
    tab[4]  = '{"flat_39",     39,  -1,   0, -1,   0, -1,   0,   0,    1,  39, 0};
    tab[5]  = '{"last_col",    40, 719,  41, -1,   0, -1,   0, 719, 1437,  41, 1};
    tab[6]  = '{"first_col",   20,   0, 250, -1,   0, -1,   0,   0,    1, 250, 1};
    tab[7]  = '{"tie_ends",     0,   0, 255, 719, 255, -1,  0,   0,    0, 255, 1};
    tab[8]  = '{"hp_right",    10, 149, 149, 150, 180, 151, 150, 150, 301, 180, 1};
    tab[9]  = '{"hp_left",     10, 149, 150, 150, 180, 151, 149, 150, 299, 180, 1};
    tab[10] = '{"hp_equal",    10, 149, 149, 150, 180, 151, 149, 150, 300, 180, 1};
    tab[11] = '{"hp_col0",     10,   0, 180,   1,  50, -1,   0,   0,   1, 180, 1};

    m_row = 0; m_armed = 1'b0;
    last_val = 0; last_col = 0; last_row = 0; last_found = 0;
    bus.px_in = 8'd0; bus.fvh_in = 3'b000; bus.dv_in = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(bus.peak_valid), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_outputs", int'({bus.peak_col, bus.peak_row, bus.peak_val, bus.peak_found}), 0);
    reset = 1'b1;
    repeat (3) cyc(8'd0, 3'b001, 1'b0);
    m_armed = 1'b1;

    // Table-driven full lines
    foreach (tab[t]) begin
      line_len = W;
      for (int i = 0; i < W; i++) line_px[i] = 8'(tab[t].bg);
      if (tab[t].c1 >= 0) line_px[tab[t].c1] = 8'(tab[t].v1);
      if (tab[t].c2 >= 0) line_px[tab[t].c2] = 8'(tab[t].v2);
      if (tab[t].c3 >= 0) line_px[tab[t].c3] = 8'(tab[t].v3);
      px_line(1'b0);
      end_line(1'b0, HALF ? tab[t].exp_hcol : tab[t].exp_col, tab[t].exp_val, tab[t].exp_found);
    end

    // Frame boundary: vblank, three lines with vblank coincident on the third
    vblank_only();
    rand_line(50, 255); model_line(1'b0, 1'b0);
    rand_line(80, 255); model_line(1'b0, 1'b0);
    rand_line(60, 255); model_line(1'b1, 1'b0);
    rand_line(40, 255); model_line(1'b0, 1'b0);
    vblank_only();
    vblank_only();

    // Empty line must not emit nor advance the row
    line_len = 0; model_line(1'b0, 1'b0);
    rand_line(30, 255); model_line(1'b0, 1'b0);

    // Gaps plus overrun: pixels beyond the last column carry the brightest value
    rand_line(730, 200);
    for (int i = W; i < 730; i++) line_px[i] = 8'd250;
    model_line(1'b0, 1'b1);

    // Randomized lines
    for (int k = 0; k < 15; k++) begin
      rand_line($urandom_range(0, 740), $urandom_range(1, 255));
      model_line($urandom_range(0, 4) == 0, 1'b1);
    end

    // Reset mid-line
    rand_line(W, 200);
    line_px[10] = 8'd220;
    model_line(1'b0, 1'b0);
    rand_line(W, 200);
    for (int i = 0; i < 400; i++) cyc(line_px[i], 3'b000, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_valid", int'(bus.peak_valid), 0);
    check("midrst_val", int'(bus.peak_val), 0);
    check("midrst_col", int'(bus.peak_col), 0);
    check("midrst_row_found_done", int'({bus.peak_row, bus.peak_found, bus.frame_done}), 0);
    cyc(line_px[400], 3'b000, 1'b1);
    cyc(line_px[401], 3'b000, 1'b1);
    reset = 1'b1;
    m_row = 0; m_armed = 1'b0;
    last_val = 0; last_col = 0; last_row = 0; last_found = 0;
    for (int i = 402; i < W; i++) cyc(line_px[i], 3'b000, 1'b1);
    end_line(1'b0, 0, 0, 0);
    rand_line(W, 255); model_line(1'b0, 1'b0);

    // Row counter saturation
    vblank_only();
    for (int k = 0; k < 1030; k++) begin
      rand_line(1, 255);
      model_line(1'b0, 1'b0);
    end
    check("row_saturated", int'(bus.peak_row), 1023);
    vblank_only();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/laser_peak_detect.md
LASER_PEAK_DETECT -- requirements
Module: laser_peak_detect

Interface
REQ-001 Parameter IMG_WIDTH, default 720: active pixels per line; the column counter saturates at IMG_WIDTH-1.
REQ-002 Parameter THRESHOLD, default 8'd40: the minimum peak intensity that counts as a laser hit.
REQ-003 clk  input  1: the single clock; all logic samples on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 px_in  input  8: blurred pixel from the upstream blur stage.
REQ-006 fvh_in  input  3: {field, vblank, hblank}, delay-aligned with px_in.
REQ-007 dv_in  input  1: pixel-valid strobe, aligned with px_in.
REQ-008 peak_col  output  10 (11 with HALF_PX_EN): column of the row maximum.
REQ-009 peak_row  output  10: line index within the frame, saturating at 1023.
REQ-010 peak_val  output  8: row maximum intensity.
REQ-011 peak_found  output  1: asserted when peak_val >= THRESHOLD.
REQ-012 peak_valid  output  1: one-cycle strobe qualifying peak_col, peak_row, peak_val and peak_found.
REQ-013 frame_done  output  1: one-cycle strobe at the end of each frame.

Function
REQ-014 A pixel SHALL be accepted only when dv_in=1 and fvh_in[1:0]=2'b00.
REQ-015 The state machine SHALL have four states, with these transitions:
- SYNC -> BLANK: on a cycle with fvh_in[0]=1.
- BLANK -> LINE: on the first accepted pixel.
- LINE -> EMIT: on a sampled rising edge of fvh_in[0] (previous 0, current 1).
- EMIT -> BLANK: unconditionally after one cycle.
REQ-016 In LINE, each accepted pixel SHALL increment col_cnt, starting from 0 and saturating at IMG_WIDTH-1; accepted pixels beyond column IMG_WIDTH-1 SHALL be ignored.
REQ-017 The running maximum SHALL update only when px_in is strictly greater than the stored maximum, so the first occurrence wins ties; the stored maximum is initialised to the line's first accepted pixel.
REQ-018 In EMIT, the block SHALL register peak_col, peak_row, peak_val and peak_found, and SHALL assert peak_valid for exactly one cycle.
REQ-019 Latency SHALL be exactly 1 cycle: peak_valid is high in the cycle following the cycle in which the hblank rising edge is sampled.
REQ-020 Outputs SHALL hold their last values when peak_valid=0.
REQ-021 The row counter SHALL increment after each EMIT and SHALL saturate at 1023.
REQ-022 On a sampled rising edge of fvh_in[1], the block SHALL clear the row counter and SHALL pulse frame_done for one cycle, provided the row counter is nonzero.
REQ-023 If the vblank and hblank rising edges coincide while in LINE, peak_valid and frame_done SHALL assert in the same cycle, and peak_row SHALL carry the pre-clear row index.
REQ-024 A line with zero accepted pixels SHALL emit nothing and SHALL NOT increment the row counter.
REQ-025 fvh_in[1] rising while in SYNC SHALL NOT produce frame_done.

Reset
REQ-026 While reset=0, all outputs SHALL be 0, the state SHALL be SYNC and all counters and the running maximum SHALL be 0.
REQ-027 Reset asserted mid-line SHALL discard the partial line; after release, no result is emitted until a full hblank-bounded line has been seen.

Configuration
REQ-028 Macro LASER_PEAK_HALF_PX_EN, when defined, SHALL make peak_col 11 bits wide, holding 2*col plus a half-pixel adjustment:
- -1 when the left neighbour is greater than the right neighbour.
- +1 when the right neighbour is greater than the left neighbour.
- 0 when the two neighbours are equal.
REQ-029 With LASER_PEAK_HALF_PX_EN defined, the left neighbour SHALL be the accepted pixel preceding the maximum (0 at column 0), and the right neighbour SHALL be the accepted pixel following it (0 if the maximum is the last pixel of the line).
REQ-030 With LASER_PEAK_HALF_PX_EN undefined, peak_col SHALL be 10 bits wide, equal to col, and no neighbour registers SHALL exist.

Verification
REQ-031 Scenario, single peak: line of 720 pixels, all 10 except col 300=200 -> peak_valid 1 cycle after hblank rise, peak_col=300, peak_val=200, peak_found=1, peak_row=0.
REQ-032 Scenario, ties and threshold: col 100=90 and col 500=90, all others 5 -> peak_col=100 (first wins); then a flat line of 30 -> peak_val=30, peak_found=0, peak_col=0.
REQ-033 Scenario, frame boundary: 3 lines, then vblank rising coincident with the third hblank rise -> peak_valid and frame_done in the same cycle, peak_row=2; next line -> peak_row=0.
REQ-034 Scenario, reset mid-line: reset=0 at col 400 -> all outputs 0 immediately; after release, the first peak_valid occurs only after a complete subsequent line.
REQ-035 Scenario, HALF_PX_EN with neighbours: neighbours 149 (col 149) and 150 (col 151), max 180 at col 150 -> peak_col=301; neighbours 150/149 -> 299; equal neighbours -> 300; max at col 0 with right neighbour 50 -> peak_col=1.
REQ-036 Scenario, gaps and overrun: dv_in gaps mid-line plus 730 accepted pixels -> gaps do not advance col_cnt, pixels beyond col 719 are ignored, and pixels during hblank are not accepted.
